shared_bus_arbiter: RTL

SHARED_BUS_ARBITER -- requirements
Module: shared_bus_arbiter

---
 rtl/shared_bus_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter multiplexing burst requesters onto one shared beat bus.
// A grant holds until a last beat transfers or the burst hits MAX_BURST beats.
module shared_bus_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 2,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      burst_trunc
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   owner_q;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   nxt_ptr;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic               own_last;
  logic               cnt_hit;
  logic               xfer;

  // grant_q is zero in IDLE, so every bus output falls to 0 there
  assign grant       = grant_q;
  assign req_ready   = grant_q & {NUM_REQ{out_ready}};
  assign out_valid   = |(req_valid & grant_q);
  assign own_last    = |(req_last & grant_q);
  assign cnt_hit     = beat_cnt_q == CNT_W'(MAX_BURST - 1);
  assign out_last    = out_valid & (own_last | cnt_hit);
  assign xfer        = out_valid & out_ready;
  assign burst_trunc = xfer & cnt_hit & ~own_last;

  assign nxt_ptr = (owner_q == PTR_W'(NUM_REQ - 1)) ?
                   '0 : owner_q + PTR_W'(1);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        out_data = out_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // First valid requester at or above rr_ptr, wrapping
  always_comb begin
    logic found;
    int   j;
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        pick  = PTR_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req_valid) begin
            state_q    <= BUSY;
            grant_q    <= NUM_REQ'(1) << pick;
            owner_q    <= pick;
            beat_cnt_q <= '0;
          end
        end
        BUSY: begin
          if (xfer) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            if (out_last) begin
              state_q  <= IDLE;
              grant_q  <= '0;
              rr_ptr_q <= nxt_ptr;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule
